asip_run_controller: RTL and testbench

- Sequences one run of the RSA/image ASIP core.
  - Latches algorithm select and sector on `start`.
  - Writes the core's config register and releases the core from reset.
  - Waits for the core's done flag (reg15).
  - Streams the result buffer out of data memory on gpio, with a valid strobe.
- Sits between board switches/buttons and the ASIP core + data RAM inside rsa_asip_system.
- Replaces bench-side timing assumptions with an explicit handshake.

---
 rtl/asip_ctrl_pkg.sv | 35 +++
 rtl/asip_stream_addr_gen.sv | 75 +++++++
 rtl/asip_run_controller.sv | 188 ++++++++++++++++++
 tb/tb_asip_run_controller.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asip_ctrl_pkg.sv
// Shared state encoding, default geometry and config-register layout for the
// ASIP run controller and its stream address generator.
package asip_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        RUN,
        STREAM,
        DONE
    } ctrl_state_e;

    localparam int DEF_ADDR_W         = 18;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_OUT_BASE       = 160000;
    localparam int DEF_OUT_WORDS_A    = 40000;
    localparam int DEF_OUT_WORDS_B    = 88804;
    localparam int DEF_TIMEOUT_CYCLES = 2 ** 24;

    // Layout of the core's 8-bit config register.
    typedef struct packed {
        logic [2:0] rsvd;
        logic       sel;
        logic [3:0] sector;
    } cfg_word_t;

    function automatic cfg_word_t pack_cfg(input logic sel, input logic [3:0] sector);
        cfg_word_t w;
        w.rsvd   = 3'b000;
        w.sel    = sel;
        w.sector = sector;
        return w;
    endfunction

endpackage

// File: rtl/asip_stream_addr_gen.sv
// Output-buffer address sequencer: issues base..base+count-1 one per cycle and
// flags each beat one cycle later to line up with a 1-cycle-latency RAM.
module asip_stream_addr_gen
    import asip_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              issued_o,
    output logic              valid_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              issued_q, issued_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    always_comb begin
        addr_d   = addr_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        issued_d = 1'b0;
        if (load_i) begin
            addr_d   = base_i;
            base_d   = base_i;
            cnt_d    = ADDR_W'(1);
            count_d  = count_i;
            issued_d = 1'b1;
        end else if (issued_q && (cnt_q < count_q)) begin
            addr_d   = base_q + cnt_q;
            cnt_d    = cnt_q + ADDR_W'(1);
            issued_d = 1'b1;
        end
        valid_d = issued_q;
        last_d  = issued_q & ~issued_d;
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            count_q  <= '0;
            issued_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign rd_addr_o = addr_q;
    assign issued_o  = issued_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;

endmodule

// File: rtl/asip_run_controller.sv
// Sequences one ASIP run: config write, core release, wait for done, stream results.
// Define ASIP_WATCHDOG_EN to add the RUN-state timeout and the sticky error flag.
module asip_run_controller
    import asip_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int OUT_BASE       = DEF_OUT_BASE,
    parameter int OUT_WORDS_A    = DEF_OUT_WORDS_A,
    parameter int OUT_WORDS_B    = DEF_OUT_WORDS_B,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              selected,
    input  logic [3:0]        sector_select,
    input  logic              core_done,
    output logic              core_rst,
    output logic              cfg_we,
    output logic [7:0]        cfg_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] gpio,
    output logic              gpio_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if ((longint'(OUT_BASE) + longint'(OUT_WORDS_A) > ADDR_SPAN) ||
        (longint'(OUT_BASE) + longint'(OUT_WORDS_B) > ADDR_SPAN)) begin : g_range_check
        $error("asip_run_controller: output buffer exceeds the ADDR_W address space");
    end

    if ((OUT_WORDS_A < 1) || (OUT_WORDS_B < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("asip_run_controller: word counts and timeout must be at least 1");
    end

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(OUT_WORDS_A);
    localparam logic [ADDR_W-1:0] WORDS_B = ADDR_W'(OUT_WORDS_B);

    ctrl_state_e       state_q, state_d;
    logic              start_q;
    logic              done_q;
    logic              sel_q, sel_d;
    logic [3:0]        sec_q, sec_d;
    logic [DATA_W-1:0] gpio_q, gpio_d;
    logic              start_edge;
    logic              done_edge;
    logic              load;
    logic              beat_issued;
    logic              beat_valid;
    logic              beat_last;

`ifdef ASIP_WATCHDOG_EN
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    assign start_edge = start & ~start_q;
    assign done_edge  = core_done & ~done_q;

    asip_stream_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .base_i   (BASE),
        .count_i  (sel_q ? WORDS_B : WORDS_A),
        .rd_addr_o(rd_addr),
        .issued_o (beat_issued),
        .valid_o  (beat_valid),
        .last_o   (beat_last)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sec_d    = sec_q;
        load     = 1'b0;
        core_rst = 1'b1;
        cfg_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
`ifdef ASIP_WATCHDOG_EN
        wd_d     = wd_q;
        error_d  = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_edge) begin
                    sel_d   = selected;
                    sec_d   = sector_select;
`ifdef ASIP_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                cfg_we  = 1'b1;
`ifdef ASIP_WATCHDOG_EN
                wd_d    = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
                core_rst = 1'b0;
                // Only a fresh 0->1 transition counts; a level left over from before RUN does not.
                if (done_edge) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
`ifdef ASIP_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            STREAM: begin
                core_rst = 1'b0;
                if (beat_last && !beat_issued) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // gpio follows the RAM word on a beat and otherwise holds the last one delivered.
    always_comb begin
        gpio_d = beat_valid ? rd_data : gpio_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            sec_q   <= '0;
            gpio_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            done_q  <= core_done;
            sel_q   <= sel_d;
            sec_q   <= sec_d;
            gpio_q  <= gpio_d;
        end
    end

`ifdef ASIP_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign cfg_data   = pack_cfg(sel_q, sec_q);
    assign gpio       = gpio_d;
    assign gpio_valid = beat_valid;

endmodule

// File: tb/tb_asip_run_controller.sv
// Self-checking bench for asip_run_controller with a small synchronous RAM model.
// Define ASIP_WATCHDOG_EN on both bench and RTL to exercise the RUN timeout.
`timescale 1ns/1ps
module tb_asip_run_controller;

    localparam int ADDR_W         = 18;
    localparam int DATA_W         = 8;
    localparam int OUT_BASE       = 16;
    localparam int OUT_WORDS_A    = 4;
    localparam int OUT_WORDS_B    = 6;
    localparam int TIMEOUT_CYCLES = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              selected = 1'b0;
    logic [3:0]        sector_select = 4'h0;
    logic              core_done = 1'b0;
    logic              core_rst;
    logic              cfg_we;
    logic [7:0]        cfg_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] gpio;
    logic              gpio_valid;
    logic              busy;
    logic              done;
    logic              error;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    asip_run_controller #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .OUT_BASE      (OUT_BASE),
        .OUT_WORDS_A   (OUT_WORDS_A),
        .OUT_WORDS_B   (OUT_WORDS_B),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .selected     (selected),
        .sector_select(sector_select),
        .core_done    (core_done),
        .core_rst     (core_rst),
        .cfg_we       (cfg_we),
        .cfg_data     (cfg_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .gpio         (gpio),
        .gpio_valid   (gpio_valid),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // Data RAM: registered read, one cycle of latency.
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        rd_data <= (rd_addr < ADDR_W'(256)) ? ram[rd_addr[7:0]] : 8'hEE;
    end

    // Observation log: everything the DUT presents, stamped with cycle numbers.
    int         cyc = 0;
    logic [7:0] cfg_log[$];
    logic [7:0] beat_log[$];
    int         beat_cyc[$];
    int         addr_log[$];
    int         done_log[$];
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (cfg_we === 1'b1) cfg_log.push_back(cfg_data);
            if (gpio_valid === 1'b1) begin
                beat_log.push_back(gpio);
                beat_cyc.push_back(cyc);
                addr_log.push_back(int'(prev_addr));
            end
            if (done === 1'b1) done_log.push_back(cyc);
        end
        prev_addr = rd_addr;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic pulse_start(input bit sel, input logic [3:0] sec);
        selected      = sel;
        sector_select = sec;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        selected      = ~sel;
        sector_select = ~sec;
    endtask

    task automatic wait_core_release(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (core_rst === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({core_rst, cfg_we, cfg_data, rd_addr, gpio, gpio_valid, busy, done, error} !==
            {1'b1, 1'b0, 8'h00, {ADDR_W{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_values: got core_rst=%b cfg_we=%b cfg_data=%h rd_addr=%0d gpio=%h valid=%b busy=%b done=%b error=%b, expected 1 0 00 0 00 0 0 0 0",
                     core_rst, cfg_we, cfg_data, rd_addr, gpio, gpio_valid, busy, done, error);
            miscompares++;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, core_rst, cfg_we} !== 3'b010) begin
            $display("FAIL idle_after_reset: got busy=%b core_rst=%b cfg_we=%b, expected 0 1 0", busy, core_rst, cfg_we);
            miscompares++;
        end
    endtask

    task automatic test_normal_run(input string tag, input bit sel, input logic [3:0] sec, input int delay);
        int         n;
        int         b0;
        int         c0;
        int         d0;
        bit         ok;
        bit         gap_ok;
        logic [7:0] exp_cfg;
        logic [7:0] got_cfg;
        logic [7:0] exp_beat;
        logic [7:0] got_beat;
        int         got_addr;
        int         last_cyc;
        n       = sel ? OUT_WORDS_B : OUT_WORDS_A;
        b0      = beat_log.size();
        c0      = cfg_log.size();
        d0      = done_log.size();
        exp_cfg = {3'b000, sel, sec};

        pulse_start(sel, sec);
        wait_core_release(ok);
        vectors++;
        if (ok !== 1'b1) begin
            $display("FAIL %s core_release: got core_rst=%b, expected 0 within 50 cycles", tag, core_rst);
            miscompares++;
        end
        repeat (delay) @(posedge clk);
        #1 core_done = 1'b1;
        wait_idle(ok);
        vectors++;
        if (ok !== 1'b1) begin
            $display("FAIL %s return_idle: got busy=%b, expected 0 within 200 cycles", tag, busy);
            miscompares++;
        end

        got_cfg = (cfg_log.size() > c0) ? cfg_log[c0] : 8'hxx;
        vectors++;
        if ((cfg_log.size() - c0 != 1) || (got_cfg !== exp_cfg)) begin
            $display("FAIL %s cfg_write: got %0d writes first=%h, expected 1 write of %h", tag, cfg_log.size() - c0, got_cfg, exp_cfg);
            miscompares++;
        end

        vectors++;
        if (beat_log.size() - b0 != n) begin
            $display("FAIL %s beat_count: got %0d, expected %0d", tag, beat_log.size() - b0, n);
            miscompares++;
        end

        gap_ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_beat = ram[OUT_BASE + k];
            got_beat = (b0 + k < beat_log.size()) ? beat_log[b0 + k] : 8'hxx;
            got_addr = (b0 + k < addr_log.size()) ? addr_log[b0 + k] : -1;
            vectors++;
            if ((got_beat !== exp_beat) || (got_addr != OUT_BASE + k)) begin
                $display("FAIL %s beat[%0d]: got data=%h addr=%0d, expected data=%h addr=%0d", tag, k, got_beat, got_addr, exp_beat, OUT_BASE + k);
                miscompares++;
            end
            if ((k > 0) && (b0 + k < beat_cyc.size()) && (beat_cyc[b0 + k] != beat_cyc[b0 + k - 1] + 1)) gap_ok = 1'b0;
        end
        vectors++;
        if (gap_ok !== 1'b1) begin
            $display("FAIL %s beats_contiguous: got gap between beats, expected back-to-back", tag);
            miscompares++;
        end

        last_cyc = (b0 + n - 1 < beat_cyc.size()) ? beat_cyc[b0 + n - 1] : -10;
        vectors++;
        if ((done_log.size() - d0 != 1) || (done_log.size() > d0 && done_log[d0] != last_cyc + 1)) begin
            $display("FAIL %s done_pulse: got %0d pulses (first at cycle %0d), expected 1 at cycle %0d", tag,
                     done_log.size() - d0, (done_log.size() > d0) ? done_log[d0] : -1, last_cyc + 1);
            miscompares++;
        end

        exp_beat = ram[OUT_BASE + n - 1];
        vectors++;
        if ({busy, core_rst, gpio_valid, error, gpio} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_beat}) begin
            $display("FAIL %s end_state: got busy=%b core_rst=%b valid=%b error=%b gpio=%h, expected 0 1 0 0 %h",
                     tag, busy, core_rst, gpio_valid, error, gpio, exp_beat);
            miscompares++;
        end
        core_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_start_held();
        int b0;
        int c0;
        int d0;
        bit ok;
        bit seen;
        b0 = beat_log.size();
        c0 = cfg_log.size();
        d0 = done_log.size();
        selected      = 1'b0;
        sector_select = 4'h3;
        start         = 1'b1;
        wait_core_release(ok);
        vectors++;
        if (ok !== 1'b1) begin
            $display("FAIL held core_release: got core_rst=%b, expected 0", core_rst);
            miscompares++;
        end
        repeat (5) @(posedge clk);
        #1 core_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (gpio_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            $display("FAIL held first_beat: got no gpio_valid, expected a beat within 30 cycles");
            miscompares++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        wait_idle(ok);
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if ((cfg_log.size() - c0 != 1) || (done_log.size() - d0 != 1) || (beat_log.size() - b0 != OUT_WORDS_A) || (busy !== 1'b0)) begin
            $display("FAIL held single_run: got cfg=%0d done=%0d beats=%0d busy=%b, expected 1 1 %0d 0",
                     cfg_log.size() - c0, done_log.size() - d0, beat_log.size() - b0, busy, OUT_WORDS_A);
            miscompares++;
        end
        core_done = 1'b0;
        start     = 1'b0;
        @(posedge clk); #1;
        test_normal_run("after_held", 1'b1, 4'h6, 3);
    endtask

    task automatic test_done_already_high();
        int b0;
        int d0;
        bit ok;
        core_done = 1'b1;
        @(posedge clk); #1;
        b0 = beat_log.size();
        d0 = done_log.size();
        pulse_start(1'b0, 4'h2);
        wait_core_release(ok);
        vectors++;
        if (ok !== 1'b1) begin
            $display("FAIL stale_done core_release: got core_rst=%b, expected 0", core_rst);
            miscompares++;
        end
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if ((beat_log.size() != b0) || (busy !== 1'b1) || (core_rst !== 1'b0)) begin
            $display("FAIL stale_done no_stream: got beats=%0d busy=%b core_rst=%b, expected 0 1 0", beat_log.size() - b0, busy, core_rst);
            miscompares++;
        end
        core_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 core_done = 1'b1;
        wait_idle(ok);
        vectors++;
        if ((ok !== 1'b1) || (beat_log.size() - b0 != OUT_WORDS_A) || (done_log.size() - d0 != 1)) begin
            $display("FAIL stale_done after_edge: got idle=%b beats=%0d done=%0d, expected 1 %0d 1", ok, beat_log.size() - b0, done_log.size() - d0, OUT_WORDS_A);
            miscompares++;
        end
        core_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream();
        int d0;
        int nb;
        bit ok;
        d0 = done_log.size();
        pulse_start(1'b0, 4'h9);
        wait_core_release(ok);
        repeat (4) @(posedge clk);
        #1 core_done = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (gpio_valid === 1'b1) nb++;
            if (nb == 2) break;
        end
        vectors++;
        if (nb != 2) begin
            $display("FAIL midrst reach_beat2: got %0d beats, expected 2", nb);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({core_rst, cfg_we, cfg_data, rd_addr, gpio, gpio_valid, busy, done, error} !==
            {1'b1, 1'b0, 8'h00, {ADDR_W{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL midrst async_values: got core_rst=%b cfg_we=%b cfg_data=%h rd_addr=%0d gpio=%h valid=%b busy=%b done=%b error=%b, expected 1 0 00 0 00 0 0 0 0",
                     core_rst, cfg_we, cfg_data, rd_addr, gpio, gpio_valid, busy, done, error);
            miscompares++;
        end
        core_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ((busy !== 1'b0) || (done_log.size() != d0)) begin
            $display("FAIL midrst quiet: got busy=%b done_pulses=%0d, expected 0 0", busy, done_log.size() - d0);
            miscompares++;
        end
        test_normal_run("post_reset", 1'b0, 4'h4, 6);
    endtask

    task automatic test_random_runs();
        bit         sel;
        logic [3:0] sec;
        int         delay;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < OUT_WORDS_B; k++) ram[OUT_BASE + k] = 8'($urandom);
            sel   = 1'($urandom_range(0, 1));
            sec   = 4'($urandom_range(0, 15));
            delay = $urandom_range(1, 12);
            test_normal_run($sformatf("random%0d", it), sel, sec, delay);
        end
    endtask

`ifdef ASIP_WATCHDOG_EN
    task automatic test_watchdog();
        int d0;
        int bad;
        bit ok;
        core_done = 1'b0;
        d0 = done_log.size();
        pulse_start(1'b1, 4'h5);
        wait_core_release(ok);
        vectors++;
        if (ok !== 1'b1) begin
            $display("FAIL wdog core_release: got core_rst=%b, expected 0", core_rst);
            miscompares++;
        end
        bad = 0;
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            @(negedge clk); #1;
            if ((error !== 1'b0) || (core_rst !== 1'b0)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL wdog early: got %0d cycles with error/core_rst set, expected 0", bad);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({error, core_rst, busy} !== 3'b110) begin
            $display("FAIL wdog expiry: got error=%b core_rst=%b busy=%b, expected 1 1 0", error, core_rst, busy);
            miscompares++;
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ((error !== 1'b1) || (done_log.size() != d0)) begin
            $display("FAIL wdog sticky: got error=%b done_pulses=%0d, expected 1 0", error, done_log.size() - d0);
            miscompares++;
        end
        pulse_start(1'b0, 4'h1);
        vectors++;
        if (error !== 1'b0) begin
            $display("FAIL wdog clear_on_start: got error=%b, expected 0", error);
            miscompares++;
        end
        wait_core_release(ok);
        repeat (3) @(posedge clk);
        #1 core_done = 1'b1;
        wait_idle(ok);
        core_done = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        for (int k = 0; k < 16; k++) ram[OUT_BASE + k] = 8'hA0 + 8'(k);

        test_reset();
        test_normal_run("run_a", 1'b0, 4'b1000, 10);
        test_normal_run("run_b", 1'b1, 4'hF, 7);
        test_start_held();
        test_done_already_high();
        test_reset_mid_stream();
`ifdef ASIP_WATCHDOG_EN
        test_watchdog();
`endif
        test_random_runs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
